// File: rtl/rs_pkg.sv
// Shared types and default parameters for the rs_latch driver.
// The state enum is also used for the debug state port.
package rs_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    PULSE,
    WAIT_FB,
    GAP,
    DONE
  } rs_state_e;

  localparam int DEF_PULSE_W = 4;
  localparam int DEF_GAP_W   = 2;
  localparam int DEF_TIMEOUT = 16;

  // One counter serves every state, so it must hold the largest count.
  function automatic int cnt_width(input int p, input int g, input int t);
    int m;
    m = p;
    if (g > m) m = g;
    if (t > m) m = t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous latch feedback pins.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs_latch_driver.sv
// Clocked driver for an external cross-coupled RS latch: one clean set/reset pulse per
// request, set and reset never high together, feedback checked through synchronizers.
module rs_latch_driver
  import rs_pkg::*;
#(
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic      clk,
  input  logic      reset,
  // Handshake: a request transfers on a rising edge where req_valid && req_ready; the
  // requester keeps req_valid/req_level stable until then. req_ready is high only in IDLE.
  input  logic      req_valid,
  input  logic      req_level,
  output logic      req_ready,
  output logic      s_out,
  output logic      r_out,
  input  logic      q_fb,
  input  logic      qn_fb,
  output logic      level,
  output logic      done,
  output logic      err_timeout,
  output logic      err_forbidden,
  input  logic      err_clr,
  output rs_state_e state
);

  localparam int CNT_W = cnt_width(PULSE_W, GAP_W, TIMEOUT);

  logic [CNT_W-1:0] cnt;
  logic             target;
  logic             from_init;
  logic             q_s;
  logic             qn_s;
  logic             forbid_prev;
  logic             forbid_now;
  logic             fb_ok;
  logic             timeout_hit;

  sync_2ff u_sync_q (
    .clk   (clk),
    .reset (reset),
    .d     (q_fb),
    .q     (q_s)
  );

  sync_2ff u_sync_qn (
    .clk   (clk),
    .reset (reset),
    .d     (qn_fb),
    .q     (qn_s)
  );

  assign forbid_now  = (state == IDLE) && (q_s == qn_s);
  assign fb_ok       = (q_s == target) && (qn_s != target);
  assign timeout_hit = (state == WAIT_FB) && !fb_ok && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= INIT;
      cnt           <= '0;
      target        <= 1'b0;
      from_init     <= 1'b0;
      s_out         <= 1'b0;
      r_out         <= 1'b0;
      req_ready     <= 1'b0;
      done          <= 1'b0;
      level         <= 1'b0;
      err_timeout   <= 1'b0;
      err_forbidden <= 1'b0;
      forbid_prev   <= 1'b0;
    end else begin
      done        <= 1'b0;
      forbid_prev <= forbid_now;

      // A new error condition in the same cycle as err_clr keeps the flag set.
      if (forbid_now && forbid_prev) err_forbidden <= 1'b1;
      else if (err_clr)              err_forbidden <= 1'b0;
      if (timeout_hit)               err_timeout   <= 1'b1;
      else if (err_clr)              err_timeout   <= 1'b0;

      case (state)
        INIT: begin
          if (cnt == CNT_W'(PULSE_W)) begin
            r_out     <= 1'b0;
            from_init <= 1'b1;
            cnt       <= '0;
            state     <= GAP;
          end else begin
            r_out <= 1'b1;
            cnt   <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            target    <= req_level;
            level     <= req_level;
            cnt       <= '0;
            // Already in the requested state and the latch agrees: skip the pulse.
            if ((req_level == level) && (q_s == req_level)) begin
              state <= DONE;
            end else begin
              s_out <= req_level;
              r_out <= ~req_level;
              state <= PULSE;
            end
          end
        end
        PULSE: begin
          if (cnt == CNT_W'(PULSE_W - 1)) begin
            s_out <= 1'b0;
            r_out <= 1'b0;
            cnt   <= '0;
            state <= WAIT_FB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_FB: begin
          if (fb_ok || timeout_hit) begin
            from_init <= 1'b0;
            cnt       <= '0;
            state     <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_W - 1)) begin
            cnt <= '0;
            if (from_init) begin
              from_init <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b1;
          req_ready <= 1'b1;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: begin
          s_out <= 1'b0;
          r_out <= 1'b0;
          cnt   <= '0;
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_latch_driver.sv
// Directed bench: the driver controls a behavioural RS latch whose feedback can be
// overridden to provoke timeout and forbidden-state errors.
module tb_rs_latch_driver;
  import rs_pkg::*;

  localparam int PW = 4;
  localparam int GW = 2;
  localparam int TO = 16;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      req_valid = 1'b0;
  logic      req_level = 1'b0;
  logic      err_clr = 1'b0;
  logic      q_fb, qn_fb;
  logic      req_ready, s_out, r_out, level, done, err_timeout, err_forbidden;
  rs_state_e state;

  logic q_lat = 1'b1;
  logic force_en = 1'b0;
  logic force_q = 1'b0;
  logic force_qn = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_c;
  int et_c;

  rs_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_level     (req_level),
    .req_ready     (req_ready),
    .s_out         (s_out),
    .r_out         (r_out),
    .q_fb          (q_fb),
    .qn_fb         (qn_fb),
    .level         (level),
    .done          (done),
    .err_timeout   (err_timeout),
    .err_forbidden (err_forbidden),
    .err_clr       (err_clr),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Cross-coupled latch, set dominant; starts at 1 so the INIT reset pulse is visible.
  always @(s_out or r_out) begin
    if (s_out)      q_lat = 1'b1;
    else if (r_out) q_lat = 1'b0;
  end

  assign q_fb  = force_en ? force_q  : q_lat;
  assign qn_fb = force_en ? force_qn : ~q_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge just after reset release; checks the INIT pulse and GAP.
  task automatic init_seq(input string tag);
    for (int c = 1; c <= PW + GW + 1; c++) begin
      @(negedge clk);
      chk({tag, "_r_out"}, 32'(r_out), 32'(c <= PW));
      chk({tag, "_s_out"}, 32'(s_out), 32'(0));
      chk({tag, "_done"}, 32'(done), 32'(0));
      chk({tag, "_ready"}, 32'(req_ready), 32'(c == PW + GW + 1));
    end
    chk({tag, "_state"}, 32'(state), 32'(IDLE));
    chk({tag, "_level"}, 32'(level), 32'(0));
    chk({tag, "_q"}, 32'(q_fb), 32'(0));
  endtask

  // Called at a negedge in IDLE; records the cycle done rose and the first err_timeout cycle.
  task automatic run_req(input string tag, input logic lvl, input logic pulse,
                         input int exp_done, output int dc, output int ec);
    logic exp_s, exp_r;
    dc = 0;
    ec = 0;
    chk({tag, "_ready_pre"}, 32'(req_ready), 32'(1));
    req_valid = 1'b1;
    req_level = lvl;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      exp_s = pulse && (c <= PW) && lvl;
      exp_r = pulse && (c <= PW) && !lvl;
      chk({tag, "_s_out"}, 32'(s_out), 32'(exp_s));
      chk({tag, "_r_out"}, 32'(r_out), 32'(exp_r));
      if (err_timeout && ec == 0) ec = c;
      if (done) begin
        dc = c;
        break;
      end
    end
    chk({tag, "_done_cycle"}, 32'(dc), 32'(exp_done));
    chk({tag, "_ready_at_done"}, 32'(req_ready), 32'(1));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'(0));
    chk({tag, "_level"}, 32'(level), 32'(lvl));
  endtask

  initial begin
    // 1: reset state, INIT reset pulse, no done
    repeat (2) @(negedge clk);
    chk("rst_s_out", 32'(s_out), 32'(0));
    chk("rst_r_out", 32'(r_out), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_err_to", 32'(err_timeout), 32'(0));
    chk("rst_err_fb", 32'(err_forbidden), 32'(0));
    chk("rst_state", 32'(state), 32'(INIT));
    reset = 1'b0;
    init_seq("init");

    // 2: set request pulses s_out for PW cycles
    run_req("set", 1'b1, 1'b1, PW + 1 + GW + 2, done_c, et_c);
    chk("set_q", 32'(q_fb), 32'(1));

    // 3: repeat of the current level skips the pulse
    run_req("same", 1'b1, 1'b0, 2, done_c, et_c);

    // 4: feedback stuck low -> timeout after TO WAIT_FB cycles, done still pulses
    force_en = 1'b1;
    force_q  = 1'b0;
    force_qn = 1'b1;
    repeat (3) @(negedge clk);
    run_req("tmo", 1'b1, 1'b1, PW + TO + GW + 2, done_c, et_c);
    chk("tmo_err_cycle", 32'(et_c), 32'(PW + TO + 1));
    chk("tmo_err_sticky", 32'(err_timeout), 32'(1));
    chk("tmo_no_forbid", 32'(err_forbidden), 32'(0));
    force_en = 1'b0;
    repeat (3) @(negedge clk);

    // 5: q==qn in IDLE for 2 synchronized cycles -> err_forbidden
    force_en = 1'b1;
    force_q  = 1'b1;
    force_qn = 1'b1;
    repeat (3) @(negedge clk);
    chk("fb_not_yet", 32'(err_forbidden), 32'(0));
    @(negedge clk);
    chk("fb_set", 32'(err_forbidden), 32'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("fb_set_wins", 32'(err_forbidden), 32'(1));
    chk("fb_clr_timeout", 32'(err_timeout), 32'(0));
    force_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("fb_sticky", 32'(err_forbidden), 32'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("fb_cleared", 32'(err_forbidden), 32'(0));
    chk("fb_to_cleared", 32'(err_timeout), 32'(0));

    // 6: reset request drives r_out, then reset aborts a set pulse mid-way
    run_req("rst_req", 1'b0, 1'b1, PW + 1 + GW + 2, done_c, et_c);
    chk("rst_req_q", 32'(q_fb), 32'(0));
    req_valid = 1'b1;
    req_level = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_s_before", 32'(s_out), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("abort_s_out", 32'(s_out), 32'(0));
    chk("abort_r_out", 32'(r_out), 32'(0));
    chk("abort_state", 32'(state), 32'(INIT));
    chk("abort_level", 32'(level), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    init_seq("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish by 100000");
    $fatal(1);
  end

endmodule
